// File: rtl/sum_pkg.sv
// Shared types and widths for the sum adder and the sum_accum frame accumulator.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

package sum_pkg;
  localparam int W = `BUS_WIDTH;

  typedef enum logic {
    ACC,
    DONE
  } acc_state_t;
endpackage

// File: rtl/sum.sv
// Combinational ripple-carry adder; the carry-out is discarded, so the result wraps modulo 2^W.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

module sum
  import sum_pkg::*;
(
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out
);

  logic carry;

  always_comb begin
    out   = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      out[i] = in1[i] ^ in2[i] ^ carry;
      carry  = (in1[i] & in2[i]) | (carry & (in1[i] ^ in2[i]));
    end
  end

endmodule

// File: rtl/sum_accum.sv
// Streaming frame accumulator: adds COUNT handshaked samples through the sum adder and
// presents the wrapped total plus a sticky carry flag on a valid/ready output.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

module sum_accum
  import sum_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  acc_state_t    state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic [W-1:0]  sum_out;
  logic          carry;
  logic          in_fire;
  logic          out_fire;

  sum u_sum (
    .in1 (acc),
    .in2 (in_data),
    .out (sum_out)
  );

  // The adder has no carry port; a wrapped result is smaller than the old accumulator.
  assign carry    = (sum_out < acc);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_fire) begin
            acc <= sum_out;
            ovf <= ovf | carry;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= sum_out;
              out_ovf   <= ovf | carry;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_fire) begin
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum: COUNT=4 instance plus a COUNT=1 instance.
`timescale 1ns/1ps

module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0] b_in_data, b_out_data;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sum_accum #(.COUNT(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_ovf   (a_out_ovf)
  );

  sum_accum #(.COUNT(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_ovf   (b_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feed one accepted sample into instance A (block must be in ACC).
  task automatic send_a(input logic [7:0] d, input string tag);
    a_in_valid = 1'b1;
    a_in_data  = d;
    chk({tag, "_in_ready"}, a_in_ready, 1);
    chk({tag, "_no_out_valid"}, a_out_valid, 0);
    tick();
  endtask

  task automatic result_a(input logic [7:0] d, input logic o, input string tag);
    chk({tag, "_out_valid"}, a_out_valid, 1);
    chk({tag, "_out_data"}, a_out_data, d);
    chk({tag, "_out_ovf"}, a_out_ovf, o);
    chk({tag, "_in_ready_low"}, a_in_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_ovf", a_out_ovf, 0);
    rst = 1'b0;

    // 1,2,3,4 back-to-back; a held sample during DONE must be ignored
    a_out_ready = 1'b1;
    send_a(8'd1, "f1a"); send_a(8'd2, "f1b"); send_a(8'd3, "f1c"); send_a(8'd4, "f1d");
    a_in_data = 8'd99;
    result_a(8'd10, 1'b0, "f1");
    tick();
    chk("f1_ret_valid", a_out_valid, 0);
    chk("f1_ret_in_ready", a_in_ready, 1);
    a_in_valid = 1'b0;

    // overflow frame then sticky-flag clear
    send_a(8'd200, "f2a"); send_a(8'd100, "f2b"); send_a(8'd1, "f2c"); send_a(8'd1, "f2d");
    a_in_valid = 1'b0;
    result_a(8'd46, 1'b1, "f2");
    tick();
    send_a(8'd0, "f3a"); send_a(8'd0, "f3b"); send_a(8'd0, "f3c"); send_a(8'd5, "f3d");
    a_in_valid = 1'b0;
    result_a(8'd5, 1'b0, "f3");
    tick();

    // in_valid toggling with junk on idle cycles; then back-pressure for 5 cycles
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_a(8'(10 * (i + 1)), "f4");
      a_in_valid = 1'b0;
      a_in_data  = 8'd77;
      if (i < 3) begin
        tick();
        chk("f4_bubble_no_valid", a_out_valid, 0);
      end
    end
    result_a(8'd100, 1'b0, "f4");
    for (int i = 0; i < 5; i++) begin
      tick();
      result_a(8'd100, 1'b0, "f4_hold");
    end
    a_out_ready = 1'b1;
    tick();
    chk("f4_ret_valid", a_out_valid, 0);
    chk("f4_ret_in_ready", a_in_ready, 1);

    // reset mid-frame discards partial sum
    send_a(8'd3, "f5a"); send_a(8'd7, "f5b");
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f5_rst_in_ready", a_in_ready, 1);
    chk("f5_rst_out_valid", a_out_valid, 0);
    a_out_ready = 1'b0;
    send_a(8'd1, "f6a"); send_a(8'd1, "f6b"); send_a(8'd1, "f6c"); send_a(8'd1, "f6d");
    a_in_valid = 1'b0;
    result_a(8'd4, 1'b0, "f6");

    // reset during DONE wins over a simultaneous output handshake
    a_out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f6_rst_out_valid", a_out_valid, 0);
    chk("f6_rst_out_data", a_out_data, 0);
    chk("f6_rst_in_ready", a_in_ready, 1);
    send_a(8'd2, "f7a"); send_a(8'd2, "f7b"); send_a(8'd2, "f7c"); send_a(8'd2, "f7d");
    a_in_valid = 1'b0;
    result_a(8'd8, 1'b0, "f7");
    tick();

    // COUNT=1 instance: every sample is a frame
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'd255 : (i == 1) ? 8'd0 : 8'd17;
      b_in_valid = 1'b1;
      b_in_data  = d;
      chk("c1_in_ready", b_in_ready, 1);
      tick();
      b_in_valid = 1'b0;
      chk("c1_out_valid", b_out_valid, 1);
      chk("c1_out_data", b_out_data, d);
      chk("c1_out_ovf", b_out_ovf, 0);
      chk("c1_in_ready_low", b_in_ready, 0);
      tick();
      chk("c1_ret_valid", b_out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
